// File: rtl/serial_rx_sipo_pkg.sv
// Shared constants for the serial receiver.
// Holds the FSM state encoding and default frame width.
package serial_rx_sipo_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_rx_sipo_bit_counter.sv
// Saturating bit counter for the receiver data phase.
// Ports: CP, n_rst, clr, inc -> count.
module bit_counter #(
  parameter int CW  = 4,
  parameter int MAX = 8
) (
  input  logic          CP,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] TOP = CW'(MAX);

  always_ff @(posedge CP or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != TOP) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx_sipo.sv
// Strobed serial-in parallel-out receiver: start 0, LSB-first data, stop 1.
// Ports: CP, n_rst, din, en -> dout, dout_valid, busy, frame_err.
module serial_rx_sipo
  import serial_rx_sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CP,
  input  logic             n_rst,
  input  logic             din,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_e        state;
  rx_state_e        state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             load;
  logic             err;

  bit_counter #(
    .CW  (CW),
    .MAX (WIDTH)
  ) u_cnt (
    .CP    (CP),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  always_ff @(posedge CP or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (en && !din) state_nx = DATA;
      DATA: if (en && cnt == LAST) state_nx = STOP;
      STOP: if (en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A low stop bit returns to IDLE; it is never reused as a start.
  always_comb begin
    busy    = (state != IDLE);
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    load    = 1'b0;
    err     = 1'b0;
    unique case (1'b1)
      (state == IDLE): cnt_clr = en && !din;
      (state == DATA): cnt_inc = en;
      (state == STOP): begin
        load = en && din;
        err  = en && !din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CP or negedge n_rst) begin
    if (!n_rst) begin
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= load;
      frame_err  <= err;
      if (cnt_inc) sr <= {din, sr[WIDTH-1:1]};
      if (load) dout <= sr;
    end
  end

endmodule

// File: tb/tb_serial_rx_sipo.sv
// Directed bench for serial_rx_sipo.
// Drives framed bytes and checks outputs against hand values.
module tb_serial_rx_sipo;

  logic       CP;
  logic       n_rst;
  logic       din;
  logic       en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       frame_err;

  int checks;
  int errors;
  int en_edges;
  int valid_cnt;
  int err_cnt;
  int both_cnt;
  int gap_bad;
  int last_valid_edge;
  int first_valid_edge;
  int start_edge;

  serial_rx_sipo #(.WIDTH(8)) dut (
    .CP         (CP),
    .n_rst      (n_rst),
    .din        (din),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    valid_cnt        = 0;
    err_cnt          = 0;
    both_cnt         = 0;
    gap_bad          = 0;
    last_valid_edge  = -1;
    first_valid_edge = -1;
  endtask

  task automatic tick(input logic d, input logic e);
    din = d;
    en  = e;
    @(posedge CP);
    #1;
    if (e) en_edges++;
    if (dout_valid) begin
      valid_cnt++;
      if (first_valid_edge < 0) first_valid_edge = en_edges;
      last_valid_edge = en_edges;
    end
    if (frame_err) err_cnt++;
    if (dout_valid && frame_err) both_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic gap);
    logic b;
    start_edge = en_edges + 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= 8) b = data[i-1];
      else b = stop;
      if (gap) begin
        tick(~b, 1'b0);
        if (i > 0 && busy !== 1'b1) gap_bad++;
        if (dout_valid || frame_err) gap_bad++;
      end
      tick(b, 1'b1);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    en_edges = 0;
    din      = 1'b1;
    en       = 1'b0;
    n_rst    = 1'b0;
    clear_stats();
    repeat (2) @(posedge CP);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    @(negedge CP);
    n_rst = 1'b1;

    // idle noise
    clear_stats();
    repeat (3) tick(1'b0, 1'b0);
    chk("noise_busy", busy, 1'b0);
    tick(1'b1, 1'b1);
    chk("noise_busy2", busy, 1'b0);
    chk("noise_valid", valid_cnt, 0);

    // good frame 0xCA
    clear_stats();
    send_frame(8'hCA, 1'b1, 1'b0);
    chk("ca_dout", dout, 8'hCA);
    chk("ca_vcnt", valid_cnt, 1);
    chk("ca_vedge", last_valid_edge - start_edge + 1, 10);
    chk("ca_err", err_cnt, 0);
    tick(1'b1, 1'b1);
    chk("ca_vpulse", valid_cnt, 1);
    chk("ca_busy", busy, 1'b0);

    // bad stop on 0x3C
    clear_stats();
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("bad_errpulse", frame_err, 1'b1);
    chk("bad_busy", busy, 1'b0);
    tick(1'b1, 1'b1);
    chk("bad_errcnt", err_cnt, 1);
    chk("bad_vcnt", valid_cnt, 0);
    chk("bad_dout", dout, 8'hCA);
    chk("bad_busy2", busy, 1'b0);

    // strobe gaps, 0x5A
    clear_stats();
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("gap_dout", dout, 8'h5A);
    chk("gap_vcnt", valid_cnt, 1);
    chk("gap_vedge", last_valid_edge - start_edge + 1, 10);
    chk("gap_hold", gap_bad, 0);

    // back to back 0xFF then 0x00
    clear_stats();
    send_frame(8'hFF, 1'b1, 1'b0);
    chk("b2b_ff", dout, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    chk("b2b_00", dout, 8'h00);
    chk("b2b_vcnt", valid_cnt, 2);
    chk("b2b_gap", last_valid_edge - first_valid_edge, 10);
    chk("both_pulse", both_cnt, 0);

    // async reset mid DATA
    clear_stats();
    send_frame(8'h81, 1'b1, 1'b0);
    chk("pre_rst_dout", dout, 8'h81);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(i[0], 1'b1);
    chk("mid_busy", busy, 1'b1);
    #3;
    n_rst = 1'b0;
    #1;
    chk("arst_dout", dout, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", dout_valid, 1'b0);
    chk("arst_err", frame_err, 1'b0);
    @(negedge CP);
    n_rst = 1'b1;
    clear_stats();
    repeat (3) tick(1'b1, 1'b1);
    chk("post_rst_pulses", valid_cnt + err_cnt, 0);
    chk("post_rst_busy", busy, 1'b0);

    // first start after reset
    clear_stats();
    send_frame(8'h33, 1'b1, 1'b0);
    chk("post_rst_dout", dout, 8'h33);
    chk("post_rst_vcnt", valid_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1);
  end

endmodule
